// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product pipeline: precision tags and default widths.
package dp_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned MODE_W     = 2;

    localparam logic [MODE_W-1:0] MODE_FP32   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_FP16X2 = 2'b01;
    localparam logic [MODE_W-1:0] MODE_BF16X2 = 2'b10;

endpackage

// File: rtl/dp_sync_fifo.sv
// Generic single-clock FIFO with explicit occupancy counter and full/empty flags.
// A push while full is accepted only if a pop frees a slot on the same edge.
module dp_sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
            else if (w_pop && !w_push) r_level <= r_level - LVL_W'(1);
        end
    end

    // Storage is deliberately not reset; the level counter guards reads.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/dp_result_out.sv
// Output stage of the dot-product pipeline: absorbs one result per cycle, presents it
// downstream with valid/ready, and accounts for results lost when the FIFO is full.
module dp_result_out
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AF_LVL = 3,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [DATA_W-1:0] p_data,
    input  logic [1:0]        p_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_mode,
    output logic              almost_full,
    output logic [LVL_W-1:0]  level,
    output logic              ovf,
    output logic [CNT_W-1:0]  drop_cnt,
    input  logic              ovf_clr
);

    logic [DATA_W+1:0] w_rdata;
    logic [LVL_W-1:0]  w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_drop_cnt;

    dp_sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (p_valid),
        .i_pop   (w_pop),
        .i_wdata ({p_mode, p_data}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_drop    = p_valid && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    // Mask the head so stale storage never leaks out while empty.
    assign out_data    = out_valid ? w_rdata[DATA_W-1:0] : '0;
    assign out_mode    = out_valid ? w_rdata[DATA_W+1:DATA_W] : 2'b00;
    assign almost_full = (w_level >= LVL_W'(AF_LVL));
    assign level       = w_level;
    assign ovf         = r_ovf;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_dp_result_out.sv
// Bench for dp_result_out: directed scenarios plus a per-cycle reference model and
// scoreboard queue that checks every handshaked result, the level and the drop accounting.
module tb_dp_result_out;
    import dp_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned CW    = 2;
    localparam int unsigned LW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p_valid = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic [1:0]    p_mode = 2'b00;
    logic          out_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_mode;
    logic          almost_full;
    logic [LW-1:0] level;
    logic          ovf;
    logic [CW-1:0] drop_cnt;

    dp_result_out #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .AF_LVL (AF),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p_valid     (p_valid),
        .p_data      (p_data),
        .p_mode      (p_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_mode    (out_mode),
        .almost_full (almost_full),
        .level       (level),
        .ovf         (ovf),
        .drop_cnt    (drop_cnt),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, evaluated mid-cycle while inputs and outputs are stable.
    logic [DW+1:0] q[$];
    int            m_level;
    logic          m_ovf;
    int            m_drop;

    initial begin
        logic [DW+1:0] exp;
        logic          hs;
        logic          pu;
        m_level = 0;
        m_ovf   = 1'b0;
        m_drop  = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_level = 0;
                m_ovf   = 1'b0;
                m_drop  = 0;
            end else begin
                check_eq("m_valid", 64'(out_valid), 64'(m_level != 0));
                check_eq("m_level", 64'(level), 64'(m_level));
                check_eq("m_afull", 64'(almost_full), 64'(m_level >= AF));
                check_eq("m_ovf", 64'(ovf), 64'(m_ovf));
                check_eq("m_drop", 64'(drop_cnt), 64'(m_drop));
                hs = (m_level != 0) && out_ready;
                if (m_level != 0) begin
                    exp = q[0];
                    check_eq("sb_data", 64'(out_data), 64'(exp[DW-1:0]));
                    check_eq("sb_mode", 64'(out_mode), 64'(exp[DW+1:DW]));
                end else begin
                    check_eq("empty_data", 64'(out_data), 64'd0);
                    check_eq("empty_mode", 64'(out_mode), 64'd0);
                end
                if (hs) exp = q.pop_front();
                pu = p_valid && (m_level < DEPTH || hs);
                if (pu) q.push_back({p_mode, p_data});
                if (ovf_clr) begin
                    m_ovf  = 1'b0;
                    m_drop = 0;
                end else if (p_valid && !pu) begin
                    m_ovf = 1'b1;
                    if (m_drop < 3) m_drop++;
                end
                m_level = m_level + (pu ? 1 : 0) - (hs ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic [1:0] m);
        p_valid = 1'b1;
        p_data  = d;
        p_mode  = m;
        tick();
        p_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (level == '0) break;
            tick();
        end
        check_eq("drain_done", 64'(level), 64'd0);
        out_ready = 1'b0;
    endtask

    task automatic single_push(input string tag);
        out_ready = 1'b1;
        push_word(32'h3F80_0000, MODE_FP32);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_data"}, 64'(out_data), 64'h3F80_0000);
        check_eq({tag, "_mode"}, 64'(out_mode), 64'(MODE_FP32));
        tick();
        check_eq({tag, "_valid_low"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_level0"}, 64'(level), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_afull", 64'(almost_full), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_drop", 64'(drop_cnt), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        #11 rst = 1'b0;
        tick();

        single_push("s1");

        // Fill with alternating FP16x2/BF16x2 tags; almost_full must rise at level 3.
        for (int i = 0; i < 4; i++) begin
            push_word(DW'(i + 1), (i % 2 == 0) ? MODE_FP16X2 : MODE_BF16X2);
            check_eq("s2_afull", 64'(almost_full), 64'(i >= 2));
        end
        check_eq("s2_level", 64'(level), 64'd4);

        push_word(32'hDEAD, MODE_FP32);
        check_eq("s3_ovf", 64'(ovf), 64'd1);
        check_eq("s3_drop", 64'(drop_cnt), 64'd1);
        check_eq("s3_level", 64'(level), 64'd4);
        check_eq("s3_head", 64'(out_data), 64'h1);

        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("clr_ovf", 64'(ovf), 64'd0);

        out_ready = 1'b1;
        push_word(32'h5, MODE_BF16X2);
        out_ready = 1'b0;
        check_eq("s4_level", 64'(level), 64'd4);
        check_eq("s4_ovf", 64'(ovf), 64'd0);
        check_eq("s4_head", 64'(out_data), 64'h2);
        drain();

        // Reserved tag fill, then enough drops to saturate a 2-bit counter.
        for (int i = 0; i < 4; i++) push_word(DW'(32'h10 + i), 2'b11);
        for (int i = 0; i < 5; i++) push_word(DW'(32'hBAD0 + i), MODE_FP32);
        check_eq("s5_sat", 64'(drop_cnt), 64'd3);
        check_eq("s5_ovf", 64'(ovf), 64'd1);
        ovf_clr = 1'b1;
        push_word(32'hBADF, MODE_FP32);
        ovf_clr = 1'b0;
        check_eq("s5_clr_ovf", 64'(ovf), 64'd0);
        check_eq("s5_clr_drop", 64'(drop_cnt), 64'd0);
        check_eq("s5_mode", 64'(out_mode), 64'h3);
        drain();

        // Continuous burst; ready stalls for the last cycles so the FIFO is full at reset.
        for (int i = 0; i < 25; i++) begin
            p_valid   = 1'b1;
            p_data    = $urandom;
            p_mode    = 2'($urandom_range(0, 3));
            out_ready = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        check_eq("s6_pre_level", 64'(level), 64'd4);
        #3 rst = 1'b1;
        #1;
        check_eq("s6_rst_valid", 64'(out_valid), 64'd0);
        check_eq("s6_rst_level", 64'(level), 64'd0);
        check_eq("s6_rst_afull", 64'(almost_full), 64'd0);
        p_valid   = 1'b0;
        out_ready = 1'b0;
        tick();
        #1 rst = 1'b0;
        tick();
        single_push("s6_post");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_result_out.md
Name: dp_result_out

Overview:
Output end of the 4D dot-product pipeline, the counterpart of the input capture stage. The arithmetic pipeline cannot stall, so this block absorbs one result per cycle from the final pipeline stage into a small FIFO. It presents results downstream with a valid/ready handshake. It raises almost_full so the issuing logic can stop launching new operand sets early enough, and it records any results lost to overflow.

Parameters:
DATA_W, 32, result word width (FP32 result, or two packed FP16 results)
DEPTH, 4, FIFO entries; must be a power of 2, minimum 2
AF_LVL, 3, occupancy at or above which almost_full asserts; range 1..DEPTH
CNT_W, 8, drop counter width

Ports:
clk  in  1  clock
rst  in  1  reset
p_valid  in  1  result valid from the last pipeline stage; no back-pressure path
p_data  in  DATA_W  result word
p_mode  in  2  precision tag travelling with the result: 00 FP32, 01 FP16x2, 10 BF16x2, 11 reserved
out_valid  out  1  head entry available
out_ready  in  1  downstream accepts the head entry
out_data  out  DATA_W  head result
out_mode  out  2  head precision tag
almost_full  out  1  occupancy >= AF_LVL
level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
ovf  out  1  sticky overflow flag
drop_cnt  out  CNT_W  number of dropped results, saturating
ovf_clr  in  1  synchronous clear of ovf and drop_cnt

Behaviour:
- Reset is asynchronous and active-high on rst; the clock is clk. All sequential logic triggers on posedge clk or posedge rst.
- Reset values: wr_ptr = 0, rd_ptr = 0, level = 0, out_valid = 0, out_data = 0, out_mode = 0, almost_full = 0, ovf = 0, drop_cnt = 0. Storage contents need not be reset.
- Storage is DEPTH x (DATA_W + 2): result word plus mode tag.
- push = p_valid. pop = out_valid & out_ready.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. level is tracked with an explicit counter.
- out_valid = (level != 0).
- out_data and out_mode come combinationally from the entry at rd_ptr. Both are forced to 0 when level == 0.
- Latency: a result pushed into an empty FIFO at edge N shows out_valid = 1 during the cycle after edge N. There is no bypass path.
- Push when not full: write at wr_ptr, then increment wr_ptr.
- Pop: increment rd_ptr.
- Push and pop in the same cycle: both pointers advance and level is unchanged. This holds when level == DEPTH, because the pop frees a slot in the same edge, so the push is accepted.
- Push while full and no pop:
  - the word is dropped and storage is unchanged;
  - ovf is set to 1;
  - drop_cnt increments, saturating at 2^CNT_W - 1.
- Pop while empty cannot occur, since out_valid = 0.
- ovf_clr = 1 clears ovf and drop_cnt to 0 at the next edge. If a drop happens in the same cycle, the clear wins and the drop is not counted.
- almost_full = (level >= AF_LVL). It is combinational from the level register.
- Mode 11 results are stored and forwarded unchanged; this block does not check mode legality.
- out_data and out_mode must stay stable while out_valid = 1 and out_ready = 0.
- Reset mid-operation discards all entries immediately. out_valid drops asynchronously together with rst.

Decomposition:
- Shared package dp_pkg holds:
  - mode encodings MODE_FP32 = 2'b00, MODE_FP16X2 = 2'b01, MODE_BF16X2 = 2'b10;
  - DATA_W default.
- One sub-module, dp_sync_fifo: generic pointer/level FIFO with full/empty outputs. dp_result_out wraps it and adds the overflow/drop accounting, almost_full, and output masking.

Test Plan:
1. Reset, then p_valid = 1 for one cycle with p_data = 0x3F800000 and p_mode = 00, out_ready = 1 -> out_valid = 1 for exactly one cycle, one cycle after the push; out_data = 0x3F800000, out_mode = 00; level returns to 0.
2. out_ready = 0, push 4 words 0x1..0x4 with alternating modes 01/10 -> level = 4, almost_full asserts on the cycle level reaches 3. Then out_ready = 1 -> 0x1..0x4 drain in order with matching modes, no gaps.
3. FIFO full, out_ready = 0, push 0xDEAD -> dropped; ovf = 1, drop_cnt = 1; later drain yields 0x1..0x4 only.
4. FIFO full, push 0x5 with out_ready = 1 in the same cycle -> 0x1 popped, 0x5 stored, level stays 4, ovf stays 0.
5. With CNT_W = 2, force 5 drops -> drop_cnt saturates at 3. Then ovf_clr = 1 together with a 6th drop -> ovf = 0, drop_cnt = 0.
6. Continuous push with random out_ready, then assert rst asynchronously mid-burst -> out_valid, level, and almost_full go to 0 immediately. Push after deassertion behaves as in scenario 1; a scoreboard confirms ordering across the whole run.
